uart_reg_bridge: RTL and testbench

- Host-side peer of the buffered UART. Consumes received bytes from the RX FIFO and decodes a byte-oriented register-access protocol.
- Runs read/write cycles on a simple 8-bit register bus and pushes response bytes into the TX FIFO.
- Sits between the UART's FIFO interface and on-chip control registers, so a PC terminal can peek and poke the design.

---
 rtl/uart_reg_bridge.sv | 81 ++++++++
 tb/tb_uart_reg_bridge.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: decodes 'W' ADDR DATA / 'R' ADDR packets from the RX FIFO into 8-bit register bus cycles and pushes replies to the TX FIFO.
module uart_reg_bridge #(
  parameter logic [7:0] ACK_BYTE = 8'h06,
  parameter logic [7:0] NAK_BYTE = 8'h15,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       UART_SRC_CK,
  input  logic       UART_RST,
  input  logic [7:0] RX_REG,
  input  logic       RX_EMPTY,
  output logic       POP_RX,
  output logic [7:0] TX_REG,
  input  logic       TX_FULL,
  output logic       PUSH_TX,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_WDATA,
  output logic       BUS_WR,
  output logic       BUS_RD,
  input  logic [7:0] BUS_RDATA,
  input  logic       BUS_ACK,
  output logic       BUSY
);
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS, RESP} state_t;
  state_t state, state_nx;
  logic pop_q, push_q, is_rd, timeout;
  logic [7:0] op, resp, resp_nx, tx_q;
  assign is_rd = op == 8'h52;
`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [31:0] cnt;
  always_ff @(posedge UART_SRC_CK or posedge UART_RST)
    if (UART_RST) cnt <= '0;
    else cnt <= (POP_RX || !(state == GET_ADDR || state == GET_DATA)) ? '0 : cnt + 32'd1;
  assign timeout = cnt == 32'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    resp_nx = resp;
    POP_RX = !UART_RST && !RX_EMPTY && !pop_q && (state == IDLE || state == GET_ADDR || state == GET_DATA);
    PUSH_TX = !UART_RST && state == RESP && !TX_FULL && !push_q;
    BUS_WR = state == BUS && !is_rd;
    BUS_RD = state == BUS && is_rd;
    BUSY = state != IDLE;
    TX_REG = PUSH_TX ? resp : tx_q;
    case (state)
      IDLE: if (POP_RX) begin
        state_nx = (RX_REG == 8'h57 || RX_REG == 8'h52) ? GET_ADDR : RESP;
        resp_nx = NAK_BYTE;
      end
      GET_ADDR: state_nx = POP_RX ? (is_rd ? BUS : GET_DATA) : timeout ? RESP : GET_ADDR;
      GET_DATA: state_nx = POP_RX ? BUS : timeout ? RESP : GET_DATA;
      BUS: if (BUS_ACK) begin
        state_nx = RESP;
        resp_nx = is_rd ? BUS_RDATA : ACK_BYTE;
      end
      RESP: state_nx = PUSH_TX ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge UART_SRC_CK or posedge UART_RST)
    if (UART_RST) begin
      state <= IDLE;
      pop_q <= 1'b0;
      push_q <= 1'b0;
      op <= '0;
      resp <= '0;
      tx_q <= '0;
      BUS_ADDR <= '0;
      BUS_WDATA <= '0;
    end else begin
      state <= state_nx;
      resp <= resp_nx;
      pop_q <= POP_RX;
      push_q <= PUSH_TX;
      if (PUSH_TX) tx_q <= resp;
      if (POP_RX && state == IDLE) op <= RX_REG;
      if (POP_RX && state == GET_ADDR) BUS_ADDR <= RX_REG;
      if (POP_RX && state == GET_DATA) BUS_WDATA <= RX_REG;
    end
endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge: scoreboard bench for uart_reg_bridge with FIFO and bus responder models.
module tb_uart_reg_bridge;
  logic clk = 0, rst = 1;
  logic [7:0] rx_reg = 0, bus_rdata = 0;
  logic rx_empty = 1, tx_full = 0, bus_ack = 0;
  logic pop_rx, push_tx, bus_wr, bus_rd, busy;
  logic [7:0] tx_reg, bus_addr, bus_wdata;
  logic [7:0] rx_q[$], exp_q[$], tx_obs[$];
  int checks = 0, passed = 0;
  int ack_delay = 0, strobe_cnt = 0;
  logic [7:0] rd_val = 0;
  int pops = 0, consec = 0, wr_cyc = 0, rd_cyc = 0, cyc = 0, pop_cyc = 0, push_cyc = 0;
  logic [7:0] wr_addr = 0, wr_data = 0, rd_addr = 0;
  logic pop_prev = 0, push_prev = 0, busy_at_push = 0, busy_after_push = 1, pop_seen = 0;

  uart_reg_bridge #(.TIMEOUT_CYCLES(50)) dut (
    .UART_SRC_CK(clk), .UART_RST(rst), .RX_REG(rx_reg), .RX_EMPTY(rx_empty), .POP_RX(pop_rx),
    .TX_REG(tx_reg), .TX_FULL(tx_full), .PUSH_TX(push_tx), .BUS_ADDR(bus_addr), .BUS_WDATA(bus_wdata),
    .BUS_WR(bus_wr), .BUS_RD(bus_rd), .BUS_RDATA(bus_rdata), .BUS_ACK(bus_ack), .BUSY(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pop_seen = pop_rx;
    #1;
    if (pop_seen && rx_q.size() > 0) void'(rx_q.pop_front());
    rx_empty = rx_q.size() == 0;
    rx_reg = rx_empty ? 8'h00 : rx_q[0];
  end

  always @(negedge clk) begin
    if (bus_wr || bus_rd) begin
      bus_ack = strobe_cnt == ack_delay;
      strobe_cnt++;
    end else begin
      bus_ack = 0;
      strobe_cnt = 0;
    end
    bus_rdata = bus_ack ? rd_val : ~rd_val;
  end

  always @(posedge clk) begin
    cyc++;
    if (pop_rx) begin
      pops++;
      pop_cyc = cyc;
      if (pop_prev) consec++;
    end
    if (push_prev) busy_after_push = busy;
    if (push_tx) begin
      tx_obs.push_back(tx_reg);
      push_cyc = cyc;
      busy_at_push = busy;
    end
    if (bus_wr) begin
      wr_cyc++;
      wr_addr = bus_addr;
      wr_data = bus_wdata;
    end
    if (bus_rd) begin
      rd_cyc++;
      rd_addr = bus_addr;
    end
    pop_prev = pop_rx;
    push_prev = push_tx;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_obs.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic start_test();
    @(negedge clk);
    pops = 0; consec = 0; wr_cyc = 0; rd_cyc = 0;
    tx_obs.delete();
  endtask

  task automatic test_reset();
    rst = 1;
    rx_q.push_back(8'h57);
    repeat (3) @(negedge clk);
    checks++;
    if ({pop_rx, push_tx, bus_wr, bus_rd, busy, tx_reg, bus_addr, bus_wdata} !== 29'd0)
      $display("FAIL reset_outputs: got %h required 0", {pop_rx, push_tx, bus_wr, bus_rd, busy, tx_reg, bus_addr, bus_wdata});
    else passed++;
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, pop_rx, push_tx} !== 3'b000) $display("FAIL reset_idle: got %b required 000", {busy, pop_rx, push_tx});
    else passed++;
  endtask

  task automatic test_write();
    logic [7:0] e;
    logic [8:0] g;
    start_test();
    ack_delay = 1;
    exp_q.push_back(8'h06);
    rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'ha5);
    wait_tx(1, 40);
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = tx_obs.size() > 0 ? {1'b0, tx_obs.pop_front()} : 9'h100;
      checks++;
      if (g !== {1'b0, e}) $display("FAIL write_resp: got %h required %h", g, e); else passed++;
    end
    checks++;
    if (wr_cyc !== 2) $display("FAIL write_strobe_len: got %0d required 2", wr_cyc); else passed++;
    checks++;
    if ({wr_addr, wr_data} !== 16'h10a5) $display("FAIL write_addr_data: got %h required 10a5", {wr_addr, wr_data}); else passed++;
    checks++;
    if (consec !== 0 || pops !== 3) $display("FAIL write_pops: got consec=%0d pops=%0d required 0/3", consec, pops); else passed++;
    checks++;
    if (bus_addr !== 8'h10) $display("FAIL write_addr_hold: got %h required 10", bus_addr); else passed++;
  endtask

  task automatic test_read();
    logic [7:0] e;
    logic [8:0] g;
    start_test();
    ack_delay = 3;
    rd_val = 8'h5a;
    busy_after_push = 1;
    busy_at_push = 0;
    exp_q.push_back(8'h5a);
    rx_q.push_back(8'h52); rx_q.push_back(8'h3c);
    wait_tx(1, 40);
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = tx_obs.size() > 0 ? {1'b0, tx_obs.pop_front()} : 9'h100;
      checks++;
      if (g !== {1'b0, e}) $display("FAIL read_resp: got %h required %h", g, e); else passed++;
    end
    checks++;
    if (rd_cyc !== 4 || rd_addr !== 8'h3c) $display("FAIL read_strobe: got len=%0d addr=%h required 4/3c", rd_cyc, rd_addr); else passed++;
    checks++;
    if ({busy_at_push, busy_after_push} !== 2'b10) $display("FAIL read_busy: got %b required 10", {busy_at_push, busy_after_push}); else passed++;
  endtask

  task automatic test_nak_then_read();
    logic [7:0] e;
    logic [8:0] g;
    start_test();
    ack_delay = 0;
    rd_val = 8'h77;
    exp_q.push_back(8'h15); exp_q.push_back(8'h77);
    rx_q.push_back(8'h41); rx_q.push_back(8'h52); rx_q.push_back(8'h01);
    wait_tx(2, 60);
    repeat (10) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = tx_obs.size() > 0 ? {1'b0, tx_obs.pop_front()} : 9'h100;
      checks++;
      if (g !== {1'b0, e}) $display("FAIL nak_resp: got %h required %h", g, e); else passed++;
    end
    checks++;
    if (tx_obs.size() !== 0) $display("FAIL nak_push_count: got %0d extra pushes required 0", tx_obs.size()); else passed++;
    checks++;
    if (rd_addr !== 8'h01 || rd_cyc !== 1) $display("FAIL nak_read: got addr=%h len=%0d required 01/1", rd_addr, rd_cyc); else passed++;
  endtask

  task automatic test_tx_full();
    logic [7:0] e;
    logic [8:0] g;
    int k = 0;
    start_test();
    ack_delay = 0;
    tx_full = 1;
    exp_q.push_back(8'h06); exp_q.push_back(8'h15);
    rx_q.push_back(8'h57); rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h99);
    while (!(wr_cyc > 0 && !bus_wr) && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (tx_obs.size() !== 0 || pops !== 3 || busy !== 1)
      $display("FAIL txfull_stall: got pushes=%0d pops=%0d busy=%b required 0/3/1", tx_obs.size(), pops, busy);
    else passed++;
    tx_full = 0;
    #1;
    checks++;
    if (push_tx !== 1'b1) $display("FAIL txfull_release_push: got %b required 1", push_tx); else passed++;
    wait_tx(2, 40);
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = tx_obs.size() > 0 ? {1'b0, tx_obs.pop_front()} : 9'h100;
      checks++;
      if (g !== {1'b0, e}) $display("FAIL txfull_resp: got %h required %h", g, e); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    logic [8:0] g;
    int k = 0;
    start_test();
    ack_delay = 1000;
    rx_q.push_back(8'h57); rx_q.push_back(8'h40); rx_q.push_back(8'h41);
    while (!bus_wr && k < 40) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if ({bus_wr, busy} !== 2'b00) $display("FAIL rstmid_async: got %b required 00", {bus_wr, busy}); else passed++;
    @(negedge clk);
    rst = 0;
    ack_delay = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_obs.size() !== 0 || busy !== 0) $display("FAIL rstmid_no_push: got pushes=%0d busy=%b required 0/0", tx_obs.size(), busy); else passed++;
    rd_val = 8'hc3;
    exp_q.push_back(8'hc3);
    rx_q.push_back(8'h52); rx_q.push_back(8'h00);
    wait_tx(1, 40);
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = tx_obs.size() > 0 ? {1'b0, tx_obs.pop_front()} : 9'h100;
      checks++;
      if (g !== {1'b0, e}) $display("FAIL rstmid_read_resp: got %h required %h", g, e); else passed++;
    end
    checks++;
    if (rd_addr !== 8'h00) $display("FAIL rstmid_read_addr: got %h required 00", rd_addr); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [8:0] g;
    start_test();
    ack_delay = 0;
    exp_q.push_back(8'h06); exp_q.push_back(8'h06);
    rx_q.push_back(8'h57); rx_q.push_back(8'h01); rx_q.push_back(8'h11);
    rx_q.push_back(8'h57); rx_q.push_back(8'h02); rx_q.push_back(8'h22);
    wait_tx(2, 60);
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = tx_obs.size() > 0 ? {1'b0, tx_obs.pop_front()} : 9'h100;
      checks++;
      if (g !== {1'b0, e}) $display("FAIL b2b_resp: got %h required %h", g, e); else passed++;
    end
    checks++;
    if ({wr_addr, wr_data} !== 16'h0222 || wr_cyc !== 2 || consec !== 0)
      $display("FAIL b2b_bus: got %h len=%0d consec=%0d required 0222/2/0", {wr_addr, wr_data}, wr_cyc, consec);
    else passed++;
  endtask

  task automatic test_partial_packet();
    logic [7:0] e;
    logic [8:0] g;
    start_test();
    ack_delay = 0;
    rx_q.push_back(8'h57); rx_q.push_back(8'h20);
`ifdef UART_BRIDGE_TIMEOUT_EN
    exp_q.push_back(8'h15);
    wait_tx(1, 120);
    checks++;
    if (push_cyc - pop_cyc < 48 || push_cyc - pop_cyc > 53)
      $display("FAIL timeout_latency: got %0d cycles required about 50", push_cyc - pop_cyc);
    else passed++;
`else
    repeat (60) @(negedge clk);
    checks++;
    if (tx_obs.size() !== 0 || busy !== 1) $display("FAIL partial_wait: got pushes=%0d busy=%b required 0/1", tx_obs.size(), busy); else passed++;
    exp_q.push_back(8'h06);
    rx_q.push_back(8'h33);
    wait_tx(1, 40);
`endif
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = tx_obs.size() > 0 ? {1'b0, tx_obs.pop_front()} : 9'h100;
      checks++;
      if (g !== {1'b0, e}) $display("FAIL partial_resp: got %h required %h", g, e); else passed++;
    end
`ifdef UART_BRIDGE_TIMEOUT_EN
    checks++;
    if (wr_cyc !== 0) $display("FAIL timeout_no_write: got %0d write cycles required 0", wr_cyc); else passed++;
`else
    checks++;
    if ({wr_addr, wr_data} !== 16'h2033) $display("FAIL partial_write: got %h required 2033", {wr_addr, wr_data}); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nak_then_read();
    test_tx_full();
    test_reset_mid();
    test_back_to_back();
    test_partial_packet();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
